// File: rtl/ddr_test_sequencer.sv
// ddr_test_sequencer: drives the per-channel fill and read engines through a
// timed test run, accumulating per-phase cycle counts over several iterations
// and reporting done/error status back to the control register block.
module ddr_test_sequencer #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned START_HOLD  = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [1:0]        cmd_mode,
  input  logic [15:0]       cmd_iterations,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] fill_start,
  input  logic [NUM_CH-1:0] fill_idle,
  output logic [NUM_CH-1:0] read_start,
  input  logic [NUM_CH-1:0] read_idle,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [15:0]       iter_count,
  output logic [63:0]       fill_cycles,
  output logic [63:0]       read_cycles
);

  localparam int unsigned KW = $clog2(START_HOLD + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, F_KICK, F_ACK, F_WAIT, R_KICK, R_ACK, R_WAIT, NEXT, FINISH
  } state_t;

  state_t            state, state_n;
  logic [1:0]        mode_q;
  logic [15:0]       iters_q;
  logic [NUM_CH-1:0] en_q, en_n;
  logic [KW-1:0]     kick_cnt;
  logic [TW-1:0]     to_cnt;
  logic [1:0]        err_n;
  logic              launch;
  logic              kick_last, ack_expired;
  logic              fill_ack, fill_fin, read_ack, read_fin;
  state_t            first_phase;

  // Disabled channels are masked out so their idle flags never matter.
  assign fill_ack    = ((fill_idle & en_q) == '0);
  assign fill_fin    = ((fill_idle & en_q) == en_q);
  assign read_ack    = ((read_idle & en_q) == '0);
  assign read_fin    = ((read_idle & en_q) == en_q);
  assign kick_last   = (kick_cnt == KW'(START_HOLD - 1));
  assign ack_expired = (to_cnt == TW'(ACK_TIMEOUT - 1));
  assign first_phase = (mode_q == 2'd1) ? R_KICK : F_KICK;
  assign busy        = (state != IDLE);

  // Next-state, latched-enable and error-code selection.
  always_comb begin
    state_n = state;
    err_n   = err_code;
    en_n    = en_q;
    launch  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_start) begin
          launch = 1'b1;
          en_n   = ch_enable;
          err_n  = 2'd0;
          if (ch_enable == '0) begin
            state_n = FINISH;
            err_n   = 2'd2;
          end else if (cmd_mode == 2'd1) begin
            state_n = R_KICK;
          end else begin
            state_n = F_KICK;
          end
        end
      end
      F_KICK: begin
        if (ack_expired) begin
          state_n = FINISH;
          err_n   = 2'd1;
        end else if (kick_last) begin
          state_n = F_ACK;
        end
      end
      F_ACK: begin
        if (fill_ack) begin
          state_n = F_WAIT;
        end else if (ack_expired) begin
          state_n = FINISH;
          err_n   = 2'd1;
        end
      end
      F_WAIT: begin
        if (fill_fin) state_n = mode_q[1] ? R_KICK : NEXT;
      end
      R_KICK: begin
        if (ack_expired) begin
          state_n = FINISH;
          err_n   = 2'd1;
        end else if (kick_last) begin
          state_n = R_ACK;
        end
      end
      R_ACK: begin
        if (read_ack) begin
          state_n = R_WAIT;
        end else if (ack_expired) begin
          state_n = FINISH;
          err_n   = 2'd1;
        end
      end
      R_WAIT: begin
        if (read_fin) state_n = NEXT;
      end
      NEXT: begin
        state_n = ((iter_count + 16'd1) == iters_q) ? FINISH : first_phase;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (cmd_abort && (state != IDLE) && (state != FINISH)) begin
      state_n = FINISH;
      err_n   = 2'd3;
    end
  end

  // State, registered start pulses, run parameters and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= '0;
      iters_q     <= '0;
      en_q        <= '0;
      kick_cnt    <= '0;
      to_cnt      <= '0;
      err_code    <= '0;
      done        <= 1'b0;
      fill_start  <= '0;
      read_start  <= '0;
      iter_count  <= '0;
      fill_cycles <= '0;
      read_cycles <= '0;
    end else begin
      state      <= state_n;
      err_code   <= err_n;
      en_q       <= en_n;
      done       <= (state_n == FINISH);
      fill_start <= (state_n == F_KICK) ? en_n : '0;
      read_start <= (state_n == R_KICK) ? en_n : '0;
      // Both counters are zero on KICK entry since KICK is only entered from
      // a state outside KICK/ACK; the timeout counter then runs through ACK.
      kick_cnt <= (state == F_KICK || state == R_KICK) ? kick_cnt + KW'(1) : '0;
      to_cnt   <= (state == F_KICK || state == R_KICK ||
                   state == F_ACK  || state == R_ACK) ? to_cnt + TW'(1) : '0;
      if (launch) begin
        mode_q      <= cmd_mode;
        iters_q     <= (cmd_iterations == '0) ? 16'd1 : cmd_iterations;
        iter_count  <= '0;
        fill_cycles <= '0;
        read_cycles <= '0;
      end else begin
        if (state == F_KICK || state == F_ACK || state == F_WAIT)
          fill_cycles <= fill_cycles + 64'd1;
        if (state == R_KICK || state == R_ACK || state == R_WAIT)
          read_cycles <= read_cycles + 64'd1;
        if (state == NEXT)
          iter_count <= iter_count + 16'd1;
      end
    end
  end

endmodule
